donkey_motion_ctrl: RTL

//  Converts keyboard ASCII events into per-frame sprite position (xpos/ypos) for the Donkey sprite drawer.

---
 rtl/donkey_pkg.sv | 34 +++
 rtl/donkey_motion_ctrl_edge_tick.sv | 24 ++
 rtl/donkey_motion_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/donkey_pkg.sv
// Shared types and constants for the Donkey sprite motion and drawing blocks.
// Latency: none (package only).
// Backpressure: none (package only).
package donkey_pkg;

    localparam int X_INIT      = 368;
    localparam int FLOOR_Y     = 536;
    localparam int X_MAX       = 736;
    localparam int STEP        = 4;
    localparam int JUMP_V      = 12;
    localparam int GRAVITY     = 1;
    localparam int HOLD_FRAMES = 8;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } motion_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    // ASCII codes of the control keys, both cases
    localparam logic [6:0] KEY_A     = 7'h61;
    localparam logic [6:0] KEY_A_UC  = 7'h41;
    localparam logic [6:0] KEY_D     = 7'h64;
    localparam logic [6:0] KEY_D_UC  = 7'h44;
    localparam logic [6:0] KEY_W     = 7'h77;
    localparam logic [6:0] KEY_W_UC  = 7'h57;
    localparam logic [6:0] KEY_SPACE = 7'h20;

endpackage

// File: rtl/donkey_motion_ctrl_edge_tick.sv
// Rising-edge detector: turns the vsync level into a one-cycle frame tick.
// Latency: tick is combinational from sig against the registered previous level.
// Backpressure: none; one tick per rising edge, never stalled.
module edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic tick
);

    logic sig_q;
    logic sig_d;

    assign sig_d = sig;

    // Remember last cycle's level of sig
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_d;
    end

    assign tick = sig & ~sig_q;

endmodule

// File: rtl/donkey_motion_ctrl.sv
// Keyboard-driven sprite motion: walk with hold timeout, jump with gravity, edge clamping.
// Latency: position/state update on the edge closing the vsync tick cycle; steady between ticks.
// Backpressure: none; keys are single-cycle strobes. Optional macro DOUBLE_JUMP_EN adds one mid-air jump.
module donkey_motion_ctrl
    import donkey_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  ascii_code,
    input  logic        ascii_new,
    input  logic        vsync,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        airborne,
    output logic        facing_left
);

    localparam logic signed [12:0] STEP13  = 13'(STEP);
    localparam logic signed [12:0] XMAX13  = 13'(X_MAX);
    localparam logic signed [12:0] FLOOR13 = 13'(FLOOR_Y);
    localparam logic signed [7:0]  JUMP8   = 8'(JUMP_V);
    localparam logic signed [7:0]  GRAV8   = 8'(GRAVITY);
    localparam logic signed [7:0]  VY_MIN  = -JUMP8;

    logic                tick;
    logic                key_left, key_right, key_jump;
    logic                dj_fire;

    logic [11:0]         x_q, x_d, y_q, y_d;
    logic signed [7:0]   vy_q, vy_d;
    motion_state_t       state_q, state_d;
    dir_t                dir_q, dir_d;
    logic                facing_left_q, facing_left_d;
    logic [3:0]          hold_cnt_q, hold_cnt_d;
    logic                jump_req_q, jump_req_d;

    logic signed [12:0]  x_ext, x_left, x_right;
    logic signed [12:0]  y_ext, vy_ext, y_new;
    logic signed [7:0]   vy_dec;

    edge_tick u_edge_tick (
        .clk  (clk),
        .rst  (rst),
        .sig  (vsync),
        .tick (tick)
    );

    assign key_left  = (ascii_code == KEY_A) || (ascii_code == KEY_A_UC);
    assign key_right = (ascii_code == KEY_D) || (ascii_code == KEY_D_UC);
    assign key_jump  = (ascii_code == KEY_W) || (ascii_code == KEY_W_UC) ||
                       (ascii_code == KEY_SPACE);

    assign x_ext   = {1'b0, x_q};
    assign x_left  = x_ext - STEP13;
    assign x_right = x_ext + STEP13;
    assign y_ext   = {1'b0, y_q};
    assign vy_ext  = 13'(vy_q);
    assign y_new   = y_ext - vy_ext;
    assign vy_dec  = vy_q - GRAV8;

`ifdef DOUBLE_JUMP_EN
    logic dj_used_q, dj_used_d;

    assign dj_fire = jump_req_q & ~dj_used_q;

    // One extra jump per airtime; re-armed while standing on the ground
    always_comb begin
        dj_used_d = dj_used_q;
        if (state_q == GROUND)
            dj_used_d = 1'b0;
        else if (tick && dj_fire)
            dj_used_d = 1'b1;
    end

    // Double-jump bookkeeping register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dj_used_q <= 1'b0;
        else     dj_used_q <= dj_used_d;
    end
`else
    assign dj_fire = 1'b0;
`endif

    // State register for motion FSM, position and key bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q           <= 12'(X_INIT);
            y_q           <= 12'(FLOOR_Y);
            vy_q          <= 8'sd0;
            state_q       <= GROUND;
            dir_q         <= RIGHT;
            facing_left_q <= 1'b0;
            hold_cnt_q    <= 4'd0;
            jump_req_q    <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            vy_q          <= vy_d;
            state_q       <= state_d;
            dir_q         <= dir_d;
            facing_left_q <= facing_left_d;
            hold_cnt_q    <= hold_cnt_d;
            jump_req_q    <= jump_req_d;
        end
    end

    // Horizontal walk: step on tick while hold is live; a key reload overrides the decrement
    always_comb begin
        x_d           = x_q;
        dir_d         = dir_q;
        facing_left_d = facing_left_q;
        hold_cnt_d    = hold_cnt_q;
        if (tick && (hold_cnt_q != 4'd0)) begin
            hold_cnt_d = hold_cnt_q - 4'd1;
            if (dir_q == LEFT)
                x_d = (x_left < 13'sd0) ? 12'd0 : x_left[11:0];
            else
                x_d = (x_right > XMAX13) ? XMAX13[11:0] : x_right[11:0];
        end
        if (ascii_new && key_left) begin
            dir_d         = LEFT;
            facing_left_d = 1'b1;
            hold_cnt_d    = 4'(HOLD_FRAMES);
        end else if (ascii_new && key_right) begin
            dir_d         = RIGHT;
            facing_left_d = 1'b0;
            hold_cnt_d    = 4'(HOLD_FRAMES);
        end
    end

    // Vertical FSM next state: launch, rise, fall with floor/ceiling clamps
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        vy_d       = vy_q;
        jump_req_d = jump_req_q;
        if (tick) begin
            case (state_q)
                GROUND: begin
                    if (jump_req_q) begin
                        vy_d       = JUMP8;
                        jump_req_d = 1'b0;
                        state_d    = RISE;
                    end
                end
                RISE, FALL: begin
                    // airborne requests are consumed or dropped on every tick
                    jump_req_d = 1'b0;
                    if (dj_fire) begin
                        vy_d    = JUMP8;
                        state_d = RISE;
                    end else if (state_q == RISE) begin
                        if (y_new < 13'sd0) begin
                            y_d     = 12'd0;
                            vy_d    = 8'sd0;
                            state_d = FALL;
                        end else begin
                            y_d  = y_new[11:0];
                            vy_d = vy_dec;
                            if (vy_dec <= 8'sd0)
                                state_d = FALL;
                        end
                    end else begin
                        if (y_new >= FLOOR13) begin
                            y_d     = FLOOR13[11:0];
                            vy_d    = 8'sd0;
                            state_d = GROUND;
                        end else begin
                            y_d  = y_new[11:0];
                            vy_d = (vy_dec < VY_MIN) ? VY_MIN : vy_dec;
                        end
                    end
                end
                default: state_d = GROUND;
            endcase
        end
        // a new jump key on the tick edge survives into the next frame
        if (ascii_new && key_jump)
            jump_req_d = 1'b1;
    end

    // Outputs are direct decodes of registered state
    always_comb begin
        xpos        = x_q;
        ypos        = y_q;
        airborne    = (state_q != GROUND);
        facing_left = facing_left_q;
    end

endmodule
